prv664_iscoreboard: RTL

Integer-register scoreboard for the prv664 dispatch stage. Each architectural integer register has a busy bit and the itag of its youngest in-flight writer. Dispatch sets these entries through two update ports. Execution-unit writebacks clear them through NWB writeback ports, but only when the writeback itag matches the stored itag. The registered busy vector and itag table go back to dispatch for hazard checks, and an empty flag goes to the system-management unit for fences.

---
 rtl/prv664_iscoreboard_if.sv | 50 +++++
 rtl/prv664_iscoreboard.sv | 110 +++++++++++
 2 files changed

// File: rtl/prv664_iscoreboard_if.sv
// prv664_iscoreboard_if
//   Signal bundle between dispatch / writeback and the integer-register
//   scoreboard. clk_i and arst_i are kept as plain ports on the scoreboard.
//   master : drives flush, the two dispatch update slots and the NWB
//            writeback ports; observes the scoreboard state.
//   slave  : the scoreboard itself.
//   Signals:
//     flush_i                          clear every entry
//     upd{0,1}_write_i/_rdindex_i/_itag_i  dispatch set ports (slot 1 younger)
//     wb_valid_i/_rdindex_i/_itag_i    flattened writeback ports, port k = slice k
//     busy_o, id_o                     per-register busy flag / stored itag
//     busy_cnt_o, empty_o              busy popcount / nothing in flight
interface prv664_iscoreboard_if #(
  parameter int NREG   = 32,
  parameter int ITAG_W = 8,
  parameter int NWB    = 2
);
  localparam int IDX_W = $clog2(NREG);

  logic                     flush_i;
  logic                     upd0_write_i;
  logic [IDX_W-1:0]         upd0_rdindex_i;
  logic [ITAG_W-1:0]        upd0_itag_i;
  logic                     upd1_write_i;
  logic [IDX_W-1:0]         upd1_rdindex_i;
  logic [ITAG_W-1:0]        upd1_itag_i;
  logic [NWB-1:0]           wb_valid_i;
  logic [NWB*IDX_W-1:0]     wb_rdindex_i;
  logic [NWB*ITAG_W-1:0]    wb_itag_i;
  logic [NREG-1:0]          busy_o;
  logic [NREG*ITAG_W-1:0]   id_o;
  logic [IDX_W:0]           busy_cnt_o;
  logic                     empty_o;

  modport master (
    output flush_i,
    output upd0_write_i, upd0_rdindex_i, upd0_itag_i,
    output upd1_write_i, upd1_rdindex_i, upd1_itag_i,
    output wb_valid_i, wb_rdindex_i, wb_itag_i,
    input  busy_o, id_o, busy_cnt_o, empty_o
  );

  modport slave (
    input  flush_i,
    input  upd0_write_i, upd0_rdindex_i, upd0_itag_i,
    input  upd1_write_i, upd1_rdindex_i, upd1_itag_i,
    input  wb_valid_i, wb_rdindex_i, wb_itag_i,
    output busy_o, id_o, busy_cnt_o, empty_o
  );
endinterface

// File: rtl/prv664_iscoreboard.sv
// prv664_iscoreboard
//   Integer-register scoreboard for the dispatch stage. Each register holds a
//   busy bit and the itag of its youngest in-flight writer. Dispatch sets
//   entries through two update ports; writebacks clear an entry only when
//   their itag matches the stored one, so stale completions never clear a
//   younger writer. Register 0 is hard-wired to not-busy / itag 0.
//   Ports:
//     clk_i   clock, rising edge
//     arst_i  asynchronous active-low reset
//     sb      prv664_iscoreboard_if.slave (updates, writebacks, state outputs)
//   Optional feature macro: ISB_WB_BYPASS_EN
//     defined   -> busy_o masks bits being cleared by a matching writeback
//                  in the current cycle (unless an update also targets them)
//     undefined -> busy_o is the registered busy vector
module prv664_iscoreboard #(
  parameter int NREG   = 32,
  parameter int ITAG_W = 8,
  parameter int NWB    = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  prv664_iscoreboard_if.slave   sb
);
  localparam int IDX_W = $clog2(NREG);
  localparam int CNT_W = IDX_W + 1;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [NREG-1:0]   upd0_hit;
  logic [NREG-1:0]   upd1_hit;
  logic [NREG-1:0]   wb_clr;
  logic [ITAG_W-1:0] itag_q [NREG];
  logic [ITAG_W-1:0] itag_d [NREG];
  logic [CNT_W-1:0]  busy_cnt;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  // Next-state: flush > younger update > older update > matching writeback.
  always_comb begin
    busy_d   = busy_q;
    upd0_hit = '0;
    upd1_hit = '0;
    wb_clr   = '0;
    for (int r = 0; r < NREG; r++) itag_d[r] = itag_q[r];

    for (int r = 1; r < NREG; r++) begin
      upd0_hit[r] = sb.upd0_write_i && (sb.upd0_rdindex_i == IDX_W'(r));
      upd1_hit[r] = sb.upd1_write_i && (sb.upd1_rdindex_i == IDX_W'(r));
      // Several ports hitting the same register simply OR together.
      for (int k = 0; k < NWB; k++) begin
        if (sb.wb_valid_i[k] &&
            (sb.wb_rdindex_i[k*IDX_W +: IDX_W] == IDX_W'(r)) &&
            (sb.wb_itag_i[k*ITAG_W +: ITAG_W] == itag_q[r]) &&
            busy_q[r])
          wb_clr[r] = 1'b1;
      end

      if (sb.flush_i) begin
        busy_d[r] = 1'b0;
        itag_d[r] = '0;
      end else if (upd1_hit[r]) begin
        busy_d[r] = 1'b1;
        itag_d[r] = sb.upd1_itag_i;
      end else if (upd0_hit[r]) begin
        busy_d[r] = 1'b1;
        itag_d[r] = sb.upd0_itag_i;
      end else if (wb_clr[r]) begin
        busy_d[r] = 1'b0;
      end
    end

    // Register 0 is constant regardless of any write to it.
    busy_d[0] = 1'b0;
    itag_d[0] = '0;
  end

  // State register stage
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) itag_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) itag_q[r] <= itag_d[r];
    end
  end

  // Outputs are derived from registered state only (busy_o bypass aside).
  always_comb begin
    sb.id_o = '0;
    for (int r = 0; r < NREG; r++) sb.id_o[r*ITAG_W +: ITAG_W] = itag_q[r];
  end

  assign busy_cnt      = popcount(busy_q);
  assign sb.busy_cnt_o = busy_cnt;
  assign sb.empty_o    = (busy_cnt == '0);

`ifdef ISB_WB_BYPASS_EN
  // A same-cycle update re-arms the entry, so it must not be masked.
  assign sb.busy_o = busy_q & ~(wb_clr & ~(upd0_hit | upd1_hit));
`else
  assign sb.busy_o = busy_q;
`endif

endmodule
